// File: rtl/rgb_pwm_pkg.sv
// Shared types and helpers for the RGB PWM controller (rgb_pwm_ctrl).
// RGB_PWM_FADE_EN is the optional fade feature macro; see rgb_pwm_chan.
package rgb_pwm_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Width of an index over n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rgb_pwm_ctrl_if.sv
// Duty-write bus between register/config logic and rgb_pwm_ctrl.
// Handshake: wr_en is a one-cycle valid strobe with no ready; the slave accepts every strobe in every state.
interface rgb_pwm_ctrl_if
  import rgb_pwm_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int PWM_W  = 8
);
  localparam int CH_W = clog2_min1(NUM_CH);

  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [PWM_W-1:0] wr_duty;

  modport master (output wr_en, output wr_ch, output wr_duty);
  modport slave  (input  wr_en, input  wr_ch, input  wr_duty);
endinterface

// File: rtl/rgb_pwm_chan.sv
// One PWM channel: shadow/active duty, boundary load (or fade step), compare and pwm flop.
// With RGB_PWM_FADE_EN defined, active walks one step per period toward shadow.
module rgb_pwm_chan #(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_hit,
  input  logic [PWM_W-1:0] wr_duty,
  input  logic             load,
  input  logic             init,
  input  logic             run,
  input  logic [PWM_W-1:0] cnt,
`ifdef RGB_PWM_FADE_EN
  output logic             busy,
`endif
  output logic             pwm
);

  logic [PWM_W-1:0] shadow_q, shadow_d;
  logic [PWM_W-1:0] active_q, active_d;
  logic             pwm_q, pwm_d;

  always_comb begin
    shadow_d = shadow_q;
    if (wr_hit) shadow_d = wr_duty;
    active_d = active_q;
    // Loads read shadow_d so a write landing in the load cycle is forwarded.
`ifdef RGB_PWM_FADE_EN
    if (init) begin
      active_d = '0;
    end else if (load) begin
      if (active_q < shadow_d)      active_d = active_q + PWM_W'(1);
      else if (active_q > shadow_d) active_d = active_q - PWM_W'(1);
    end
`else
    if (init || load) active_d = shadow_d;
`endif
    pwm_d = run && (cnt < active_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm = pwm_q;
`ifdef RGB_PWM_FADE_EN
  assign busy = (active_q != shadow_q);
`endif

endmodule

// File: rtl/rgb_pwm_ctrl.sv
// Multi-channel PWM LED controller: prescaler, shared PWM counter and CURREN/RGBLEDEN sequencer.
// Optional fade (RGB_PWM_FADE_EN) adds the fade_busy output.
module rgb_pwm_ctrl
  import rgb_pwm_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int PWM_W     = 8,
  parameter int PRESC_DIV = 64,
  parameter int WARM_CYC  = 4800
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  rgb_pwm_ctrl_if.slave     wr_bus,
  output logic              curren,
  output logic              rgbleden,
  output logic [NUM_CH-1:0] pwm,
  output logic              ready,
  output logic              period_start,
`ifdef RGB_PWM_FADE_EN
  output logic              fade_busy,
`endif
  output state_e            dbg_state
);

  localparam int CH_W   = clog2_min1(NUM_CH);
  localparam int PSC_W  = clog2_min1(PRESC_DIV);
  localparam int WARM_W = clog2_min1(WARM_CYC);
  localparam logic [PSC_W-1:0]  PSC_MAX  = PSC_W'(PRESC_DIV - 1);
  localparam logic [WARM_W-1:0] WARM_MAX = WARM_W'(WARM_CYC - 1);

  state_e             state_q, state_d;
  logic [WARM_W-1:0]  warm_q, warm_d;
  logic [PSC_W-1:0]   psc_q, psc_d;
  logic [PWM_W-1:0]   cnt_q, cnt_d;
  logic               curren_q, curren_d;
  logic               rgbleden_q, rgbleden_d;
  logic               period_start_q, period_start_d;
  logic               run_stay, tick, boundary, load_init;

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    case (state_q)
      ST_OFF: begin
        if (en) begin
          state_d = ST_WARM;
          warm_d  = '0;
        end
      end
      ST_WARM: begin
        if (!en) begin
          state_d = ST_OFF;
          warm_d  = '0;
        end else if (warm_q == WARM_MAX) begin
          state_d = ST_RUN;
          warm_d  = '0;
        end else begin
          warm_d = warm_q + WARM_W'(1);
        end
      end
      ST_RUN: begin
        if (!en) state_d = ST_OFF;
      end
      default: begin
        state_d = ST_OFF;
        warm_d  = '0;
      end
    endcase
  end

  // Counters advance only while staying in RUN, so shutdown clears them next cycle.
  always_comb begin
    run_stay  = (state_q == ST_RUN) && (state_d == ST_RUN);
    tick      = (state_q == ST_RUN) && (psc_q == PSC_MAX);
    boundary  = tick && (cnt_q == '1);
    load_init = (state_q == ST_OFF) && (state_d == ST_WARM);
    psc_d     = '0;
    cnt_d     = '0;
    if (run_stay) begin
      psc_d = tick ? '0 : psc_q + PSC_W'(1);
      cnt_d = tick ? cnt_q + PWM_W'(1) : cnt_q;
    end
    period_start_d = boundary && run_stay;
    curren_d       = (state_d != ST_OFF);
    rgbleden_d     = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_OFF;
      warm_q         <= '0;
      psc_q          <= '0;
      cnt_q          <= '0;
      curren_q       <= 1'b0;
      rgbleden_q     <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      warm_q         <= warm_d;
      psc_q          <= psc_d;
      cnt_q          <= cnt_d;
      curren_q       <= curren_d;
      rgbleden_q     <= rgbleden_d;
      period_start_q <= period_start_d;
    end
  end

`ifdef RGB_PWM_FADE_EN
  logic [NUM_CH-1:0] busy_vec;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    rgb_pwm_chan #(.PWM_W(PWM_W)) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_hit  (wr_bus.wr_en && (wr_bus.wr_ch == CH_W'(i))),
      .wr_duty (wr_bus.wr_duty),
      .load    (boundary),
      .init    (load_init),
      .run     (run_stay),
      .cnt     (cnt_q),
`ifdef RGB_PWM_FADE_EN
      .busy    (busy_vec[i]),
`endif
      .pwm     (pwm[i])
    );
  end

`ifdef RGB_PWM_FADE_EN
  assign fade_busy = |busy_vec;
`endif

  assign curren       = curren_q;
  assign rgbleden     = rgbleden_q;
  assign ready        = rgbleden_q;
  assign period_start = period_start_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Directed testbench for rgb_pwm_ctrl (NUM_CH=3, PWM_W=4, PRESC_DIV=2, WARM_CYC=8).
// Define RGB_PWM_FADE_EN to run the fade sequence instead of the jump-load sequence.
module tb_rgb_pwm_ctrl;
  import rgb_pwm_pkg::*;

  localparam int NUM_CH    = 3;
  localparam int PWM_W     = 4;
  localparam int PRESC_DIV = 2;
  localparam int WARM_CYC  = 8;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic              curren;
  logic              rgbleden;
  logic [NUM_CH-1:0] pwm;
  logic              ready;
  logic              period_start;
  state_e            dbg_state;
`ifdef RGB_PWM_FADE_EN
  logic              fade_busy;
`endif

  int total = 0;
  int bad   = 0;

  rgb_pwm_ctrl_if #(.NUM_CH(NUM_CH), .PWM_W(PWM_W)) wr_bus ();

  rgb_pwm_ctrl #(
    .NUM_CH(NUM_CH), .PWM_W(PWM_W), .PRESC_DIV(PRESC_DIV), .WARM_CYC(WARM_CYC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .wr_bus       (wr_bus),
    .curren       (curren),
    .rgbleden     (rgbleden),
    .pwm          (pwm),
    .ready        (ready),
    .period_start (period_start),
`ifdef RGB_PWM_FADE_EN
    .fade_busy    (fade_busy),
`endif
    .dbg_state    (dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard comparison
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Driver tasks (called at a negedge, return at a negedge)
  task automatic wr(input logic [1:0] ch, input logic [PWM_W-1:0] duty);
    wr_bus.wr_en   = 1'b1;
    wr_bus.wr_ch   = ch;
    wr_bus.wr_duty = duty;
    @(negedge clk);
    wr_bus.wr_en = 1'b0;
  endtask

  // Raise en from OFF and check the full warm-up sequence.
  task automatic seq_check(input string tag);
    en = 1'b1;
    check({tag, "_curren_pre"}, curren, 1'b0);
    @(negedge clk);
    check({tag, "_curren_rise"}, {curren, rgbleden, ready}, 3'b100);
    for (int i = 1; i < WARM_CYC; i++) begin
      @(negedge clk);
      check({tag, "_warm"}, {rgbleden, ready, pwm}, 5'b0);
    end
    @(negedge clk);
    check({tag, "_run_rise"}, {curren, rgbleden, ready}, 3'b111);
    check({tag, "_state_run"}, dbg_state, ST_RUN);
  endtask

  task automatic wait_ps();
    int n = 0;
    while (period_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ps_seen", period_start, 1'b1);
  endtask

  // Called at a period_start negedge; counts one full period of pwm highs.
  task automatic measure(input bit do_wr, input int at, input logic [1:0] ch,
                         input logic [PWM_W-1:0] duty,
                         output int h0, output int h1, output int h2, output int ps);
    h0 = 0; h1 = 0; h2 = 0; ps = 0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      h0 += int'(pwm[0]);
      h1 += int'(pwm[1]);
      h2 += int'(pwm[2]);
      ps += int'(period_start);
      if (do_wr && i == at) begin
        wr_bus.wr_en   = 1'b1;
        wr_bus.wr_ch   = ch;
        wr_bus.wr_duty = duty;
      end else begin
        wr_bus.wr_en = 1'b0;
      end
    end
  endtask

  int h0, h1, h2, ps;

  initial begin
    rst_n          = 1'b0;
    en             = 1'b0;
    wr_bus.wr_en   = 1'b0;
    wr_bus.wr_ch   = '0;
    wr_bus.wr_duty = '0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {curren, rgbleden, ready, period_start, pwm}, 7'b0);
    check("rst_state", dbg_state, ST_OFF);
    rst_n = 1'b1;
    @(negedge clk);

`ifndef RGB_PWM_FADE_EN
    // Duties written while OFF, then sequencing and steady PWM
    wr(2'd0, 4'd4);
    wr(2'd1, 4'd0);
    wr(2'd2, 4'd15);
    check("off_pwm", pwm, 3'b000);
    seq_check("seq1");
    wait_ps();
    measure(1'b0, 0, 2'd0, 4'd0, h0, h1, h2, ps);
    check("p1_h0", h0, 8);
    check("p1_h1", h1, 0);
    check("p1_h2", h2, 30);
    check("p1_ps", ps, 1);

    // Mid-period write keeps the current period
    measure(1'b1, 10, 2'd0, 4'd12, h0, h1, h2, ps);
    check("mid_cur_h0", h0, 8);
    check("mid_cur_h2", h2, 30);
    // Boundary-cycle write (offset 31 = cnt 15, psc 1) is forwarded
    measure(1'b1, 31, 2'd0, 4'd2, h0, h1, h2, ps);
    check("mid_next_h0", h0, 24);
    check("mid_next_ps", ps, 1);
    measure(1'b0, 0, 2'd0, 4'd0, h0, h1, h2, ps);
    check("bnd_h0", h0, 4);
    check("bnd_h1", h1, 0);

    // Shutdown while pwm0 is high
    repeat (2) @(negedge clk);
    check("sd_pwm0_high", pwm[0], 1'b1);
    en = 1'b0;
    @(negedge clk);
    check("sd_outputs", {curren, rgbleden, ready, pwm}, 6'b0);
    check("sd_state", dbg_state, ST_OFF);
    repeat (2) @(negedge clk);
    check("sd_hold", {curren, rgbleden, period_start, pwm}, 6'b0);
    seq_check("seq2");
    wait_ps();
    // Illegal channel write during this period must not change anything
    measure(1'b1, 5, 2'd3, 4'd9, h0, h1, h2, ps);
    check("ret_h0", h0, 4);
    check("ret_h2", h2, 30);
    measure(1'b0, 0, 2'd0, 4'd0, h0, h1, h2, ps);
    check("ill_h0", h0, 4);
    check("ill_h1", h1, 0);
    check("ill_h2", h2, 30);

    // Asynchronous reset mid-RUN
    repeat (3) @(negedge clk);
    check("pre_rst_pwm", pwm, 3'b101);
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", {curren, rgbleden, ready, period_start, pwm}, 7'b0);
    check("async_rst_state", dbg_state, ST_OFF);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    seq_check("seq3");
    wait_ps();
    measure(1'b0, 0, 2'd0, 4'd0, h0, h1, h2, ps);
    check("rst_shadow_clear", h0 + h1 + h2, 0);
`else
    // Fade: active steps 0 -> 1 -> 2 -> 3 over successive boundaries
    wr(2'd0, 4'd3);
    seq_check("fade");
    check("fade_busy_warm", fade_busy, 1'b1);
    wait_ps();
    check("fade_busy_1", fade_busy, 1'b1);
    measure(1'b0, 0, 2'd0, 4'd0, h0, h1, h2, ps);
    check("fade_d1", h0, 2);
    check("fade_busy_2", fade_busy, 1'b1);
    measure(1'b0, 0, 2'd0, 4'd0, h0, h1, h2, ps);
    check("fade_d2", h0, 4);
    check("fade_busy_3", fade_busy, 1'b0);
    measure(1'b0, 0, 2'd0, 4'd0, h0, h1, h2, ps);
    check("fade_d3", h0, 6);
    check("fade_other", h1 + h2, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_ctrl.md
Name: rgb_pwm_ctrl

Overview:
- Parametrised multi-channel PWM LED controller for the SoM's hard RGB current driver.
- Generates per-channel PWM waveforms from a shared prescaled counter.
- Sequences the driver enables: CURREN first, then a warm-up delay, then RGBLEDEN.
- Duty updates are glitch-free, taking effect only at period boundaries.
- Sits between the register/config logic and the RGB driver primitive wrapper, which consumes curren, rgbleden and pwm[].

Parameters:
- NUM_CH, 3: number of PWM channels (1..8).
- PWM_W, 8: PWM counter and duty width in bits; period = 2^PWM_W ticks.
- PRESC_DIV, 64: clk cycles per PWM tick (>=1).
- WARM_CYC, 4800: clk cycles CURREN is held before RGBLEDEN asserts (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  level; 1 = run LEDs, 0 = shut down
- wr_en  in  1  one-cycle duty write strobe
- wr_ch  in  $clog2(NUM_CH) (min 1)  target channel of the write
- wr_duty  in  PWM_W  duty value to write
- curren  out  1  to driver CURREN
- rgbleden  out  1  to driver RGBLEDEN
- pwm  out  NUM_CH  to driver RGBnPWM
- ready  out  1  high while in RUN
- period_start  out  1  one-cycle pulse at each PWM period boundary

Behaviour:
- Reset (asynchronous, any state):
  - Outputs: curren=0, rgbleden=0, pwm=0, ready=0, period_start=0.
  - All counters 0; shadow and active duty registers 0; FSM=OFF.
- Clock requirement: one clock only, with all logic on the rising edge of clk.
- Prescaler:
  - psc counts 0..PRESC_DIV-1 and wraps.
  - tick=1 when psc==PRESC_DIV-1.
  - PRESC_DIV=1 gives tick every cycle.
- PWM counter:
  - cnt (PWM_W bits) increments on tick and wraps 2^PWM_W-1 -> 0.
  - Boundary = tick && cnt==2^PWM_W-1.
  - period_start is registered and high in the cycle after the boundary (cnt==0).
- Prescaler and PWM counter run only in RUN; they are held at 0 in other states.
- Duty writes:
  - wr_en stores wr_duty into shadow[wr_ch].
  - wr_ch >= NUM_CH is ignored.
  - Writes are accepted in every state.
- Duty load:
  - At the boundary, active[i] <= shadow[i].
  - A write landing in the boundary cycle is forwarded, so active gets wr_duty for that channel.
  - On the OFF->WARM transition, active <= shadow (with the same forwarding).
- PWM output:
  - pwm[i] is registered: 1 when state==RUN && cnt < active[i].
  - duty 0 = always low; duty 2^PWM_W-1 = high for 2^PWM_W-1 of 2^PWM_W ticks.
  - Output latency from counter to pwm is 1 cycle.
- FSM states OFF, WARM, RUN:
  - OFF: curren=0, rgbleden=0. If en=1, go to WARM and clear the warm counter.
  - WARM: curren=1. Warm counter increments each cycle; when it reaches WARM_CYC-1, go to RUN. If en=0, go to OFF.
  - RUN: curren=1, rgbleden=1, ready=1. If en=0, go to OFF.
- Outputs are registered from the next state:
  - curren rises 1 cycle after en rises.
  - rgbleden and ready rise exactly WARM_CYC cycles after curren.
- Shutdown (en falling, any state):
  - Next cycle: pwm=0, rgbleden=0, curren=0, ready=0, counters cleared.
  - Shadow registers are retained.
- en re-asserted in the same cycle it could leave OFF: the normal OFF->WARM transition applies; there is no RUN bypass.

Optional Feature:
- Macro RGB_PWM_FADE_EN.
- Defined: at each boundary, active[i] steps by 1 toward shadow[i] instead of jumping (+1 if less, -1 if greater, hold if equal). The OFF->WARM load sets active to 0, so LEDs fade in from dark. Adds output fade_busy (1 bit), high while any active != shadow; it resets to 0.
- Undefined: active jumps directly to shadow as described above, and the fade_busy port does not exist.

Decomposition:
- Shared package rgb_pwm_pkg:
  - FSM state enum (OFF=2'd0, WARM=2'd1, RUN=2'd2).
  - Function clog2_min1 for the wr_ch width.
- Sub-module rgb_pwm_chan, instantiated NUM_CH times: holds shadow, active, compare, the fade step and the pwm flop.
- The top level keeps the prescaler, PWM counter and FSM.

Test Plan:
- Common setup: NUM_CH=3, PWM_W=4, PRESC_DIV=2, WARM_CYC=8.
- Sequencing: hold en=1 from reset release -> curren rises 1 cycle later; rgbleden and ready rise 8 cycles after curren; pwm stays 0 throughout WARM.
- Duty: write ch0=4, ch1=0, ch2=15, then enable -> per 32-cycle period, pwm0 high 8 cycles, pwm1 never high, pwm2 high 30 cycles; period_start pulses every 32 cycles.
- Glitch-free update: in RUN, write ch0=12 mid-period -> the current period keeps 8 high cycles; the next period has 24. A write in the boundary cycle applies in the immediately following period.
- Shutdown: drop en in RUN while pwm0=1 -> next cycle pwm=0, rgbleden=0, curren=0, ready=0. Re-enable -> a full 8-cycle WARM occurs again and duties are retained.
- Reset mid-RUN plus illegal write: assert rst_n=0 asynchronously -> all outputs 0 immediately. A write with wr_ch=3 has no effect on any channel.
- With RGB_PWM_FADE_EN defined: shadow ch0=3, then enable -> ch0 duty goes 1, 2, 3 over three successive periods; fade_busy deasserts after the third boundary.
